// File: rtl/output_port_arbiter.sv
// Output-port arbiter: round-robin grant on head flits, wormhole lock until the
// owning packet's tail, and a one-entry registered output stage toward the link.
module output_port_arbiter #(
    parameter int N_PORTS    = 5,
    parameter int FLIT_WIDTH = 37,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic [N_PORTS-1:0]            req_valid_i,
    input  logic [N_PORTS*FLIT_WIDTH-1:0] req_flit_i,
    output logic [N_PORTS-1:0]            req_ready_o,
    output logic [FLIT_WIDTH-1:0]         flit_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          busy_o,
    output logic [CNT_WIDTH-1:0]          pkt_cnt_o
);

    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {
        FT_HEAD      = 2'b00,
        FT_BODY      = 2'b01,
        FT_TAIL      = 2'b10,
        FT_HEAD_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                 state_q;
    logic [PW-1:0]          rr_ptr_q;
    logic [PW-1:0]          owner_q;
    logic [FLIT_WIDTH-1:0]  flit_q;
    logic                   valid_q;
    logic                   busy_q;
    logic [CNT_WIDTH-1:0]   cnt_q;

    logic                   can_load;
    logic [N_PORTS-1:0]     eligible;
    logic [2*N_PORTS-1:0]   rot_full;
    logic [N_PORTS-1:0]     rotated;
    logic                   found;
    int                     wsum;
    logic [PW-1:0]          winner;
    logic [PW-1:0]          sel;
    logic [N_PORTS-1:0]     grant;
    logic [FLIT_WIDTH-1:0]  sel_flit;
    flit_type_e             sel_type;
    logic                   xfer;

    assign can_load = !valid_q || ready_i;

    // Head and head_tail are exactly the types whose two type bits are equal.
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            eligible[i] = req_valid_i[i] &&
                          (req_flit_i[i*FLIT_WIDTH + FLIT_WIDTH-1] ==
                           req_flit_i[i*FLIT_WIDTH + FLIT_WIDTH-2]);
        end
    end

    // Rotate so bit 0 is the port just after rr_ptr, then take the first set bit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        found    = 1'b0;
        wsum     = 0;
        winner   = '0;
        rot_full = {eligible, eligible} >> (int'(rr_ptr_q) + 1);
        rotated  = rot_full[N_PORTS-1:0];
        for (int j = 0; j < N_PORTS; j++) begin
            if (!found && rotated[j]) begin
                found = 1'b1;
                wsum  = int'(rr_ptr_q) + 1 + j;
            end
        end
        if (wsum >= N_PORTS) begin
            winner = PW'(wsum - N_PORTS);
        end else begin
            winner = PW'(wsum);
        end
    end

    always_comb begin
        grant = '0;
        if (can_load) begin
            case (state_q)
                IDLE:    if (found) grant[winner] = 1'b1;
                LOCKED:  grant[owner_q] = req_valid_i[owner_q];
                default: grant = '0;
            endcase
        end
    end

    assign sel         = (state_q == IDLE) ? winner : owner_q;
    assign sel_flit    = req_flit_i[sel*FLIT_WIDTH +: FLIT_WIDTH];
    assign sel_type    = flit_type_e'(sel_flit[FLIT_WIDTH-1 -: 2]);
    assign xfer        = |grant;
    assign req_ready_o = grant;

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the same pre-edge values.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q  <= IDLE;
            rr_ptr_q <= PW'(N_PORTS - 1);
            owner_q  <= '0;
            flit_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (xfer) begin
                flit_q  <= sel_flit;
                valid_q <= 1'b1;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end

            if (xfer) begin
                case (state_q)
                    IDLE: begin
                        rr_ptr_q <= winner;
                        if (sel_type == FT_HEAD) begin
                            state_q <= LOCKED;
                            owner_q <= winner;
                            busy_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                        end
                    end
                    LOCKED: begin
                        // A head arriving from the owner while locked is passed on as body.
                        if (sel_type == FT_TAIL) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            cnt_q   <= cnt_q + CNT_WIDTH'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign flit_o    = flit_q;
    assign valid_o   = valid_q;
    assign busy_o    = busy_q;
    assign pkt_cnt_o = cnt_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed scenarios plus random traffic, all
// checked against a packet-level model with a flit scoreboard.
module tb_output_port_arbiter;

    localparam int N  = 5;
    localparam int FW = 37;
    localparam int CW = 4;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    logic            clk = 1'b0;
    logic            arst;
    logic [N-1:0]    req_valid_i;
    logic [N*FW-1:0] req_flit_i;
    logic [N-1:0]    req_ready_o;
    logic [FW-1:0]   flit_o;
    logic            valid_o;
    logic            ready_i;
    logic            busy_o;
    logic [CW-1:0]   pkt_cnt_o;

    output_port_arbiter #(.N_PORTS(N), .FLIT_WIDTH(FW), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .arst        (arst),
        .req_valid_i (req_valid_i),
        .req_flit_i  (req_flit_i),
        .req_ready_o (req_ready_o),
        .flit_o      (flit_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .pkt_cnt_o   (pkt_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [N-1:0]  v;
    logic [FW-1:0] f [N];
    logic [N-1:0]  last_rdy;

    bit            m_locked;
    int            m_owner;
    int            m_rr;
    logic          m_valid;
    logic [FW-1:0] m_out;
    int            m_cnt;
    logic [FW-1:0] sb [$];

    function automatic logic [FW-1:0] mk(input logic [1:0] t);
        logic [34:0] payload;
        payload = 35'({$urandom(), $urandom()});
        return {t, payload};
    endfunction

    function automatic logic [1:0] ftype(input logic [FW-1:0] x);
        return x[FW-1 -: 2];
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_owner  = 0;
        m_rr     = N - 1;
        m_valid  = 1'b0;
        m_out    = '0;
        m_cnt    = 0;
        sb.delete();
    endtask

    task automatic clear_inputs();
        v = '0;
        for (int i = 0; i < N; i++) f[i] = '0;
        ready_i = 1'b1;
    endtask

    // Which input the arbiter should accept this cycle, from the packet rules.
    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_valid && !ready_i) return g;
        if (m_locked) begin
            if (v[m_owner]) g[m_owner] = 1'b1;
            return g;
        end
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (m_rr + k) % N;
            if (v[p] && (ftype(f[p]) == T_HEAD || ftype(f[p]) == T_HT)) begin
                g[p] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // One clock: drive, compare grant and drained flit, clock, compare outputs.
    task automatic step();
        logic [N-1:0]  exp_rdy;
        logic [FW-1:0] exp_f;
        int            p;
        req_valid_i = v;
        for (int i = 0; i < N; i++) req_flit_i[i*FW +: FW] = f[i];
        #1;
        exp_rdy  = model_grant();
        last_rdy = req_ready_o;
        checks++;
        if (req_ready_o !== exp_rdy) begin
            errors++;
            $display("FAIL req_ready t=%0t: got %b expected %b", $time, req_ready_o, exp_rdy);
        end
        if (m_valid && ready_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t: got flit %h expected none", $time, flit_o);
            end else begin
                exp_f = sb.pop_front();
                if (flit_o !== exp_f) begin
                    errors++;
                    $display("FAIL scoreboard_order t=%0t: got %h expected %h", $time, flit_o, exp_f);
                end
            end
        end
        @(posedge clk);
        if (exp_rdy != '0) begin
            p = 0;
            for (int i = 0; i < N; i++) if (exp_rdy[i]) p = i;
            sb.push_back(f[p]);
            m_out   = f[p];
            m_valid = 1'b1;
            if (!m_locked) begin
                m_rr = p;
                if (ftype(f[p]) == T_HEAD) begin
                    m_locked = 1;
                    m_owner  = p;
                end else begin
                    m_cnt = (m_cnt + 1) % (1 << CW);
                end
            end else if (ftype(f[p]) == T_TAIL) begin
                m_locked = 0;
                m_cnt    = (m_cnt + 1) % (1 << CW);
            end
        end else if (ready_i) begin
            m_valid = 1'b0;
        end
        #1;
        checks++;
        if (valid_o !== m_valid) begin
            errors++;
            $display("FAIL valid_o t=%0t: got %b expected %b", $time, valid_o, m_valid);
        end
        checks++;
        if (busy_o !== m_locked) begin
            errors++;
            $display("FAIL busy_o t=%0t: got %b expected %b", $time, busy_o, m_locked);
        end
        checks++;
        if (pkt_cnt_o !== CW'(m_cnt)) begin
            errors++;
            $display("FAIL pkt_cnt t=%0t: got %0d expected %0d", $time, pkt_cnt_o, m_cnt);
        end
        if (m_valid) begin
            checks++;
            if (flit_o !== m_out) begin
                errors++;
                $display("FAIL flit_o t=%0t: got %h expected %h", $time, flit_o, m_out);
            end
        end
    endtask

    task automatic test_reset();
        arst = 1'b0;
        clear_inputs();
        req_valid_i = '0;
        req_flit_i  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || flit_o !== '0 || pkt_cnt_o !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b b=%b f=%h c=%0d expected all zero",
                     valid_o, busy_o, flit_o, pkt_cnt_o);
        end
        arst = 1'b1;
    endtask

    task automatic test_single_head_tail();
        clear_inputs();
        v[2] = 1'b1;
        f[2] = mk(T_HT);
        step();
        checks++;
        if (last_rdy !== 5'b00100) begin
            errors++;
            $display("FAIL single_grant: got %b expected 00100", last_rdy);
        end
        clear_inputs();
        step();
        checks++;
        if (pkt_cnt_o !== CW'(1)) begin
            errors++;
            $display("FAIL single_count: got %0d expected 1", pkt_cnt_o);
        end
    endtask

    task automatic test_alternate();
        logic [N-1:0] prev;
        clear_inputs();
        prev = '0;
        for (int c = 0; c < 6; c++) begin
            v[0] = 1'b1; f[0] = mk(T_HT);
            v[3] = 1'b1; f[3] = mk(T_HT);
            step();
            if (c > 0) begin
                checks++;
                if (last_rdy === prev || !(last_rdy === 5'b00001 || last_rdy === 5'b01000)) begin
                    errors++;
                    $display("FAIL alternate: got %b after %b expected the other of 0/3", last_rdy, prev);
                end
            end
            prev = last_rdy;
        end
        clear_inputs();
        step();
    endtask

    task automatic test_wormhole();
        logic [1:0] seq [4];
        seq = '{T_HEAD, T_BODY, T_BODY, T_TAIL};
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            v[1] = 1'b1;
            f[1] = mk(seq[c]);
            if (c > 0) begin
                v[4] = 1'b1;
                f[4] = mk(T_HEAD);
            end
            step();
            checks++;
            if (last_rdy !== 5'b00010) begin
                errors++;
                $display("FAIL wormhole_lock c=%0d: got %b expected 00010", c, last_rdy);
            end
        end
        v[1] = 1'b0;
        step();
        checks++;
        if (last_rdy !== 5'b10000) begin
            errors++;
            $display("FAIL wormhole_next: got %b expected 10000", last_rdy);
        end
        v[4] = 1'b1;
        f[4] = mk(T_TAIL);
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_backpressure();
        clear_inputs();
        for (int c = 0; c < 8; c++) begin
            v[1]    = 1'b1;
            f[1]    = mk(T_HT);
            ready_i = !(c >= 2 && c < 5);
            step();
            if (c >= 3 && c < 5) begin
                checks++;
                if (last_rdy !== '0) begin
                    errors++;
                    $display("FAIL backpressure_ready c=%0d: got %b expected 00000", c, last_rdy);
                end
            end
        end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_protocol_error();
        clear_inputs();
        step();
        v[0] = 1'b1;
        f[0] = mk(T_BODY);
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (last_rdy !== '0 || valid_o !== 1'b0) begin
                errors++;
                $display("FAIL stray_body c=%0d: got ready=%b valid=%b expected 00000/0", c, last_rdy, valid_o);
            end
        end
        f[0] = mk(T_TAIL);
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        v[3] = 1'b1;
        f[3] = mk(T_HEAD);
        step();
        v[3] = 1'b0;
        arst = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || pkt_cnt_o !== '0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b b=%b c=%0d expected 0/0/0", valid_o, busy_o, pkt_cnt_o);
        end
        model_reset();
        clear_inputs();
        v[0] = 1'b1; f[0] = mk(T_HEAD);
        v[3] = 1'b1; f[3] = mk(T_HEAD);
        #2;
        arst = 1'b1;
        step();
        checks++;
        if (last_rdy !== 5'b00001) begin
            errors++;
            $display("FAIL reset_priority: got %b expected 00001", last_rdy);
        end
        clear_inputs();
        v[0] = 1'b1;
        f[0] = mk(T_TAIL);
        step();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [1:0] t;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                v[i] = ($urandom_range(0, 9) < 6);
                t    = 2'($urandom_range(0, 3));
                f[i] = mk(t);
            end
            ready_i = ($urandom_range(0, 3) != 0);
            step();
        end
        clear_inputs();
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single_head_tail();
        test_alternate();
        test_wormhole();
        test_backpressure();
        test_protocol_error();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
